// File: rtl/joy_pkg.sv
// joy_pkg: shared constants and FSM state type for the DB15 joystick scanner.
//   NUM_BITS        - bits per serial frame (two players)
//   BITS_PER_PLAYER - bits belonging to one player
//   R..LB           - button positions inside one player's 12-bit word
//   state_t         - scan FSM states
package joy_pkg;

  localparam int NUM_BITS        = 24;
  localparam int BITS_PER_PLAYER = 12;

  localparam int R  = 0;
  localparam int L  = 1;
  localparam int D  = 2;
  localparam int U  = 3;
  localparam int A  = 4;
  localparam int B  = 5;
  localparam int C  = 6;
  localparam int D2 = 7;
  localparam int E  = 8;
  localparam int F  = 9;
  localparam int S  = 10;
  localparam int LB = 11;

  typedef enum logic {
    ST_LOAD  = 1'b0,
    ST_SHIFT = 1'b1
  } state_t;

endpackage

// File: rtl/clk_en_div.sv
// clk_en_div: free-running clock-enable divider.
//   clk   - system clock
//   reset - synchronous, active-high; clears the count
//   tick  - high for one clk every DIV clocks (when count == DIV-1)
module clk_en_div #(
  parameter int DIV = 24
) (
  input  logic clk,
  input  logic reset,
  output logic tick
);

  logic [7:0] cnt;

  assign tick = (cnt == 8'(DIV - 1));

  always_ff @(posedge clk) begin
    if (reset)     cnt <= '0;
    else if (tick) cnt <= '0;
    else           cnt <= cnt + 8'd1;
  end

endmodule

// File: rtl/joy_db15_scan.sv
// joy_db15_scan: scans two DB15 joysticks through an external 74HC165 chain.
//   clk, reset         - system clock, synchronous active-high reset
//   joy_clk, joy_load  - shift clock / active-low parallel load to the chain
//   joy_data           - serial data from the chain (buttons active-low)
//   joystick1/2        - registered, active-high button words {4'b0, 12 buttons}
//   frame_done         - one-clk pulse at the end of every 24-bit frame
// Frame = 2 load ticks + 24 bits * 2 half-ticks = 50 ticks.
module joy_db15_scan
  import joy_pkg::*;
#(
  parameter int CLK_DIV = 24,
  parameter bit FILTER  = 1'b1
) (
  input  logic        clk,
  input  logic        reset,
  output logic        joy_clk,
  output logic        joy_load,
  input  logic        joy_data,
  output logic [15:0] joystick1,
  output logic [15:0] joystick2,
  output logic        frame_done
);

  logic tick;

  clk_en_div #(.DIV(CLK_DIV)) u_div (
    .clk  (clk),
    .reset(reset),
    .tick (tick)
  );

  state_t                state_q, state_d;
  logic [1:0]            lcnt_q, lcnt_d;
  logic [4:0]            bit_q, bit_d;
  logic                  half_q, half_d;      // 0 = low half of a bit, 1 = high half
  logic                  jclk_q, jclk_d;
  logic                  jload_q, jload_d;
  logic [NUM_BITS-1:0]   shift_q, shift_d;
  logic [NUM_BITS-1:0]   prev_q;
  logic                  primed_q;            // prev_q holds a real frame
  logic                  done_d;
  logic                  frame_done_q;
  logic [15:0]           joy1_q, joy2_q;

  assign joy_clk    = jclk_q;
  assign joy_load   = jload_q;
  assign frame_done = frame_done_q;
  assign joystick1  = joy1_q;
  assign joystick2  = joy2_q;

  // The load stretch is counted 0..2: leaving reset we sit at 0 with the
  // load still released, so the first tick only pulls it low. The end of a
  // frame pulls the load low itself and enters at 1, keeping the period at
  // exactly 50 ticks.
  always_comb begin
    state_d = state_q;
    lcnt_d  = lcnt_q;
    bit_d   = bit_q;
    half_d  = half_q;
    jclk_d  = jclk_q;
    jload_d = jload_q;
    shift_d = shift_q;
    done_d  = 1'b0;
    if (tick) begin
      case (state_q)
        ST_LOAD: begin
          if (lcnt_q == 2'd2) begin
            jload_d = 1'b1;
            state_d = ST_SHIFT;
            lcnt_d  = 2'd0;
            bit_d   = 5'd0;
            half_d  = 1'b0;
          end else begin
            jload_d = 1'b0;
            jclk_d  = 1'b0;
            lcnt_d  = lcnt_q + 2'd1;
          end
        end
        ST_SHIFT: begin
          if (!half_q) begin
            // sample before our rising edge shifts the chain
            shift_d[bit_q] = ~joy_data;
            jclk_d         = 1'b1;
            half_d         = 1'b1;
          end else begin
            jclk_d = 1'b0;
            half_d = 1'b0;
            if (bit_q == 5'(NUM_BITS - 1)) begin
              done_d  = 1'b1;
              state_d = ST_LOAD;
              jload_d = 1'b0;
              lcnt_d  = 2'd1;
              bit_d   = 5'd0;
            end else begin
              bit_d = bit_q + 5'd1;
            end
          end
        end
        default: state_d = ST_LOAD;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= ST_LOAD;
      lcnt_q       <= 2'd0;
      bit_q        <= 5'd0;
      half_q       <= 1'b0;
      jclk_q       <= 1'b0;
      jload_q      <= 1'b1;
      shift_q      <= '0;
      prev_q       <= '0;
      primed_q     <= 1'b0;
      frame_done_q <= 1'b0;
      joy1_q       <= '0;
      joy2_q       <= '0;
    end else begin
      state_q      <= state_d;
      lcnt_q       <= lcnt_d;
      bit_q        <= bit_d;
      half_q       <= half_d;
      jclk_q       <= jclk_d;
      jload_q      <= jload_d;
      shift_q      <= shift_d;
      frame_done_q <= done_d;
      if (done_d) begin
        // bit 23 was captured on the previous tick, so shift_q is complete
        if (!FILTER || (primed_q && shift_q == prev_q)) begin
          joy1_q <= {4'b0, shift_q[LB:R]};
          joy2_q <= {4'b0, shift_q[NUM_BITS-1:BITS_PER_PLAYER]};
        end
        prev_q   <= shift_q;
        primed_q <= 1'b1;
      end
    end
  end

endmodule

// File: doc/joy_db15_scan.md
JOY_DB15_SCAN -- requirements
Module: joy_db15_scan

Interface
REQ-001 SHALL have parameter CLK_DIV, default 24: system clocks per shift tick, legal range 2..255.
REQ-002 SHALL have parameter FILTER, default 1: 1 = two-frame match before output update; 0 = update every frame.
REQ-003 SHALL have port clk, input, 1: the single clock for the block (40-50 MHz).
REQ-004 SHALL have port reset, input, 1: synchronous, active-high.
REQ-005 SHALL have port joy_clk, output, 1: shift clock to the external 74HC165 chain.
REQ-006 SHALL have port joy_load, output, 1: active-low parallel load to the chain.
REQ-007 SHALL have port joy_data, input, 1: serial data from the chain; active-low buttons.
REQ-008 SHALL have port joystick1, output, 16: player 1 mapping, {4'b0, L, S, F, E, D, C, B, A, U, D, L, R}, active-high.
REQ-009 SHALL have port joystick2, output, 16: player 2, same mapping as joystick1.
REQ-010 SHALL have port frame_done, output, 1: one-cycle pulse when each 24-bit frame completes.

Function
REQ-011 SHALL assert internal tick for one clk when the divider count equals CLK_DIV-1; the count then wraps to 0.
REQ-012 SHALL run FSM states LOAD and SHIFT, changing all outputs only on tick.
REQ-013 LOAD SHALL hold joy_load=0 and joy_clk=0 for 2 ticks, then enter SHIFT with joy_load=1 and bit index 0.
REQ-014 SHIFT SHALL split each bit into a low half and a high half. At the tick ending the low half, it SHALL sample joy_data and drive joy_clk=1. At the tick ending the high half, it SHALL drive joy_clk=0 and increment the bit index.
REQ-015 SHALL store sampled bit i, inverted, at shift position i. Bits 0-11 are player 1 bits 0-11; bits 12-23 are player 2 bits 0-11.
REQ-016 At the high-half tick of bit 23, SHALL pulse frame_done for one clk, then return to LOAD.
REQ-017 Frame period SHALL be exactly 50*CLK_DIV clk cycles.
REQ-018 With FILTER=1, SHALL update joystick1/2 only when the new 24-bit frame equals the previous frame; the previous-frame register is updated every frame.
REQ-019 With FILTER=0, SHALL update joystick1/2 from every completed frame.
REQ-020 SHALL register joystick1/2 and update them together in the cycle frame_done is asserted, so the two words never show a torn update.
REQ-021 joystick1[15:12] and joystick2[15:12] SHALL always be 0.
REQ-022 SHALL discard any partial frame; no partial frame ever reaches the outputs.

Reset
REQ-023 On reset=1 at a clk edge: divider=0, state=LOAD, bit index=0, joy_clk=0, joy_load=1, joystick1=0, joystick2=0, frame_done=0, shift and previous-frame registers=0.
REQ-024 Reset asserted mid-frame SHALL abort the frame with no output change other than the REQ-023 values.
REQ-025 With FILTER=1, the first frame after reset SHALL only fill the previous-frame register and SHALL NOT update the outputs, even if all bits are released.
REQ-026 The first LOAD tick after reset SHALL occur CLK_DIV cycles after reset deasserts.

Structure
REQ-027 A shared package joy_pkg SHALL hold: NUM_BITS=24; BITS_PER_PLAYER=12; button index constants (R=0, L=1, D=2, U=3, A=4, B=5, C=6, D2=7, E=8, F=9, S=10, LB=11); the FSM state enum.
REQ-028 The divider SHALL be a sub-module clk_en_div (parameter DIV; ports clk, reset, tick).
REQ-029 All outputs SHALL be driven directly from flops.

Verification (CLK_DIV=4, frame = 200 cycles)
REQ-030 Reset then idle, joy_data=1: first frame_done at cycle 204 ±1; with FILTER=1, outputs stay 0 through frame 2.
REQ-031 Model holds player 1 bit 4 and player 2 bit 10 (data=0 at bits 4 and 22) steady: after frame 2, joystick1=16'h0010 and joystick2=16'h0400.
REQ-032 FILTER=1, button pressed for one frame only: outputs unchanged. FILTER=0, same stimulus: joystick1 follows the frame and clears on the next frame.
REQ-033 Reset pulsed at bit 13 of a frame: joy_load=1, joy_clk=0 and outputs=0 next cycle; LOAD restarts and the partial data never appears on the outputs.
REQ-034 Check joy_clk and joy_load waveforms: load-low for 8 clks, then 24 clk pulses each 4 high / 4 low. Sampling must occur at the rising joy_clk edge; a model changing data 1 clk after the rising edge must still read correctly.
REQ-035 All buttons held (data=0): joystick1 = joystick2 = 16'h0FFF, and bits 15:12 stay 0.
